// File: rtl/prescale_timer_if.sv
// Signal bundle for prescale_timer: count-control inputs from the
// surrounding logic and the timer's registered status outputs.
interface prescale_timer_if #(
    parameter int WIDTH = 8
) ();
    logic             enable;
    logic             tick_in;
    logic [WIDTH-1:0] divisor;
    logic             load;
    logic             oneshot;
    logic             start;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic [WIDTH-1:0] div_active;

    // The controlling side drives the strobes and the divisor.
    modport master (
        output enable, tick_in, divisor, load, oneshot, start,
        input  tick, count, busy, div_active
    );

    // The timer itself.
    modport slave (
        input  enable, tick_in, divisor, load, oneshot, start,
        output tick, count, busy, div_active
    );
endinterface

// File: rtl/prescale_timer.sv
// Programmable prescaler / timer with periodic and one-shot modes.
// The count advances on enable & tick_in while running and wraps at
// div_active-1 (a divisor of 0 means 2^WIDTH). A divisor loaded while
// running is held pending and takes effect at the next wrap, so the
// period already in progress always completes.
module prescale_timer #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    prescale_timer_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             mode_reg, mode_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [WIDTH-1:0] pend_val_reg, pend_val_next;
    logic             pend_reg, pend_next;
    logic             tick_reg, tick_next;
    logic             busy_reg;

    logic             advance;
    logic             wrap;
    logic [WIDTH-1:0] term_count;

    // Modulo subtraction maps divisor 0 onto a terminal count of all ones.
    assign term_count = div_reg - WIDTH'(1);
    assign advance    = (state_reg == RUN) && bus.enable && bus.tick_in;
    assign wrap       = advance && (count_reg == term_count);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, count, divisor and pending-reload decisions.
    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        count_next    = count_reg;
        div_next      = div_reg;
        pend_val_next = pend_val_reg;
        pend_next     = pend_reg;
        tick_next     = wrap;

        unique case (state_reg)
            IDLE: begin
                // Nothing is counting, so a new divisor applies at once.
                if (bus.load) begin
                    div_next   = bus.divisor;
                    count_next = '0;
                    pend_next  = 1'b0;
                end
                if (bus.oneshot ? bus.start : bus.enable) begin
                    state_next = RUN;
                    mode_next  = bus.oneshot;
                end
            end
            RUN: begin
                if (wrap) begin
                    count_next = '0;
                    // A load landing on the wrap edge wins over any older
                    // pending value, which is discarded.
                    if (bus.load) begin
                        div_next = bus.divisor;
                    end else if (pend_reg) begin
                        div_next = pend_val_reg;
                    end
                    pend_next = 1'b0;
                    if (mode_reg) begin
                        state_next = IDLE;
                    end
                end else begin
                    if (advance) begin
                        count_next = count_reg + WIDTH'(1);
                    end
                    if (bus.load) begin
                        pend_val_next = bus.divisor;
                        pend_next     = 1'b1;
                    end
                end
                // Periodic runs stop when enable drops; one-shot runs only pause.
                if (!mode_reg && !bus.enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg     <= 1'b0;
            count_reg    <= '0;
            div_reg      <= '0;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            tick_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            count_reg    <= count_next;
            div_reg      <= div_next;
            pend_val_reg <= pend_val_next;
            pend_reg     <= pend_next;
            tick_reg     <= tick_next;
            busy_reg     <= (state_next == RUN);
        end
    end

    assign bus.tick       = tick_reg;
    assign bus.count      = count_reg;
    assign bus.busy       = busy_reg;
    assign bus.div_active = div_reg;
endmodule

// File: tb/tb_prescale_timer.sv
// Randomized and directed bench for prescale_timer against a cycle-level
// behavioural model built from the timer's rules (period as an integer
// 1..256, run/idle flag, pending reload).
module tb_prescale_timer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    prescale_timer_if #(.WIDTH(WIDTH)) bus ();

    prescale_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: what the outputs must show after the coming edge.
    bit m_run, m_mode, m_tick, m_pend;
    int m_cnt, m_per, m_pval;

    int tick_seen;
    int max_count_seen;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit adv, wrap;
        int per_in;
        per_in = (bus.divisor == 0) ? 256 : int'(bus.divisor);
        if (reset) begin
            m_run  = 0; m_mode = 0; m_tick = 0; m_pend = 0;
            m_cnt  = 0; m_per  = 256;
        end else begin
            adv    = m_run && bus.enable && bus.tick_in;
            wrap   = adv && (m_cnt == m_per - 1);
            m_tick = wrap;
            if (!m_run) begin
                if (bus.load) begin
                    m_per = per_in; m_cnt = 0; m_pend = 0;
                end
                if (bus.oneshot ? bus.start : bus.enable) begin
                    m_run = 1; m_mode = bus.oneshot;
                end
            end else begin
                if (wrap) begin
                    m_cnt = 0;
                    if (bus.load) m_per = per_in;
                    else if (m_pend) m_per = m_pval;
                    m_pend = 0;
                    if (m_mode) m_run = 0;
                end else begin
                    if (adv) m_cnt++;
                    if (bus.load) begin
                        m_pend = 1; m_pval = per_in;
                    end
                end
                if (!m_mode && !bus.enable) m_run = 0;
            end
        end
    endtask

    // One clock: predict, clock, compare all outputs.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_val("count", int'(bus.count), m_cnt);
        check_val("tick", int'(bus.tick), int'(m_tick));
        check_val("busy", int'(bus.busy), int'(m_run));
        check_val("div_active", int'(bus.div_active), m_per % 256);
        if (bus.tick) tick_seen++;
        if (int'(bus.count) > max_count_seen) max_count_seen = int'(bus.count);
    endtask

    task automatic drive(input bit en, input bit ti, input int div,
                         input bit ld, input bit os, input bit st);
        bus.enable  = en;
        bus.tick_in = ti;
        bus.divisor = WIDTH'(div);
        bus.load    = ld;
        bus.oneshot = os;
        bus.start   = st;
        cycle();
    endtask

    task automatic idle_load(input int div, input bit os);
        drive(0, 1, div, 0, os, 0);
        drive(0, 1, div, 1, os, 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        bus.enable = 0; bus.tick_in = 1; bus.divisor = '0;
        bus.load = 0; bus.oneshot = 0; bus.start = 0;
        cycle();
        cycle();
        check_val("reset_busy", int'(bus.busy), 0);
        check_val("reset_div", int'(bus.div_active), 0);
        reset = 1'b0;
        $display("txn reset checks=%0d", checks);

        // Periodic, divisor 5: two wraps in ten advances.
        drive(1, 1, 5, 1, 0, 0);
        tick_seen = 0;
        for (int i = 0; i < 10; i++) drive(1, 1, 5, 0, 0, 0);
        check_val("periodic5_ticks", tick_seen, 2);
        $display("txn periodic5 checks=%0d", checks);

        // Cascade and pause, divisor 3.
        idle_load(3, 0);
        tick_seen = 0;
        for (int i = 0; i < 24; i++) drive(1, i % 2, 3, 0, 0, 0);
        check_val("cascade_ticks", tick_seen, 4);
        for (int i = 0; i < 3; i++) drive(1, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 3, 0, 0, 0);
        check_val("pause_busy", int'(bus.busy), 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 3, 0, 0, 0);
        $display("txn cascade_pause checks=%0d", checks);

        // One-shot, divisor 4, with a redundant start mid-run.
        idle_load(4, 1);
        tick_seen = 0;
        drive(1, 1, 4, 0, 1, 1);
        drive(1, 1, 4, 0, 1, 0);
        drive(1, 1, 4, 0, 1, 1);
        for (int i = 0; i < 8; i++) drive(1, 1, 4, 0, 1, 0);
        check_val("oneshot_ticks", tick_seen, 1);
        check_val("oneshot_idle", int'(bus.busy), 0);
        check_val("oneshot_count", int'(bus.count), 0);
        $display("txn oneshot checks=%0d", checks);

        // Reload in RUN, then a load coinciding with the wrap.
        idle_load(6, 0);
        drive(1, 1, 6, 0, 0, 0);
        guard = 0;
        while (m_cnt != 1 && guard < 50) begin drive(1, 1, 6, 0, 0, 0); guard++; end
        check_val("reload_reach", int'(guard < 50), 1);
        drive(1, 1, 2, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 2, 0, 0, 0);
        guard = 0;
        while (m_cnt != m_per - 1 && guard < 50) begin drive(1, 1, 2, 0, 0, 0); guard++; end
        drive(1, 1, 3, 1, 0, 0);
        check_val("coincident_div", int'(bus.div_active), 3);
        for (int i = 0; i < 9; i++) drive(1, 1, 3, 0, 0, 0);
        $display("txn reload checks=%0d", checks);

        // Divisor 1: a tick after every advance.
        idle_load(1, 0);
        drive(1, 1, 1, 0, 0, 0);
        tick_seen = 0;
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 0, 0, 0);
        check_val("div1_ticks", tick_seen, 6);
        $display("txn div1 checks=%0d", checks);

        // Divisor 0: period 256, count reaches 255.
        idle_load(0, 0);
        tick_seen = 0;
        max_count_seen = 0;
        for (int i = 0; i < 258; i++) drive(1, 1, 0, 0, 0, 0);
        check_val("div0_max", max_count_seen, 255);
        check_val("div0_ticks", tick_seen, 1);
        $display("txn div0 checks=%0d", checks);

        // Reset landing on the wrap cycle suppresses the tick.
        idle_load(5, 0);
        guard = 0;
        drive(1, 1, 5, 0, 0, 0);
        while (m_cnt != 4 && guard < 50) begin drive(1, 1, 5, 0, 0, 0); guard++; end
        reset = 1'b1;
        drive(1, 1, 5, 0, 0, 0);
        reset = 1'b0;
        check_val("wrap_reset_tick", int'(bus.tick), 0);
        drive(0, 1, 5, 0, 0, 0);
        check_val("after_reset_tick", int'(bus.tick), 0);
        $display("txn wrap_reset checks=%0d", checks);

        // Random traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                int dv;
                reset = ($urandom_range(0, 199) == 0);
                dv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 7));
                drive($urandom_range(0, 99) < 85, $urandom_range(0, 3) != 0, dv,
                      $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 9) == 0);
            end
            reset = 1'b0;
            $display("txn random_seg%0d checks=%0d", seg, checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
